// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-port write/read request arbiter feeding a one-entry
// registered memory command stage, with a tag FIFO that steers returning
// read beats back to the port that issued the burst.
module mem_req_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_BITS    = 25,
  parameter int DATA_WIDTH   = 128,
  parameter int READ_BURST   = 8,
  parameter int TAG_DEPTH    = 8,
  parameter int WRITE_STREAK = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]  i_waddr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wdata,
  input  logic [NUM_PORTS-1:0]            i_wdata_have,
  output logic [NUM_PORTS-1:0]            o_wdata_accept,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]  i_raddr,
  input  logic [NUM_PORTS-1:0]            i_rdata_req,
  output logic [NUM_PORTS-1:0]            o_rdata_req_accepted,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic [NUM_PORTS-1:0]            o_rdata_valid,
  output logic                            o_rdata_lastword,
  output logic [ADDR_BITS-1:0]            o_mem_address,
  output logic [DATA_WIDTH-1:0]           o_mem_wdata,
  output logic [3:0]                      o_mem_size,
  output logic                            o_mem_write_req,
  output logic                            o_mem_read_req,
  output logic                            o_mem_burstbegin,
  output logic                            o_err_unexpected,
  output logic [$clog2(TAG_DEPTH):0]      o_outstanding,
  input  logic                            i_mem_ready,
  input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
  input  logic                            i_mem_rdata_valid,
  input  logic                            i_mem_init_done
);

  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TAW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW  = $clog2(TAG_DEPTH) + 1;
  localparam int SW  = $clog2(WRITE_STREAK + 1);

  typedef enum logic {
    WRITE_PRI = 1'b0,
    READ_PRI  = 1'b1
  } mode_t;

  // Per-port views of the packed request buses
  logic [ADDR_BITS-1:0]  waddr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [ADDR_BITS-1:0]  raddr_arr [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign waddr_arr[gi] = i_waddr[gi*ADDR_BITS +: ADDR_BITS];
    assign wdata_arr[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign raddr_arr[gi] = i_raddr[gi*ADDR_BITS +: ADDR_BITS];
  end

  // Round-robin search starting one past the last granted port; returns {found, index}
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    logic          found;
    logic [PW-1:0] sel;
    idx   = ptr;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (idx == PW'(NUM_PORTS - 1)) idx = '0;
      else                           idx = idx + PW'(1);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State
  logic                  init_done_reg;
  logic                  stage_full_reg;
  logic                  stage_write_reg;
  logic [ADDR_BITS-1:0]  stage_addr_reg;
  logic [DATA_WIDTH-1:0] stage_data_reg;
  mode_t                 mode_reg, mode_next;
  logic [SW-1:0]         streak_reg, streak_next;
  logic [PW-1:0]         wptr_reg, rptr_reg;
  logic [PW-1:0]         tag_mem [TAG_DEPTH];
  logic [TAW-1:0]        tag_wr_reg, tag_rd_reg;
  logic [CW-1:0]         tag_count_reg;
  logic [3:0]            beat_cnt_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [NUM_PORTS-1:0]  rvalid_reg;
  logic                  last_reg;
  logic                  err_reg;

  // Combinational control
  logic          present, consume, can_load;
  logic          have_tag, last_beat, pop, tag_space;
  logic          w_found, r_found;
  logic [PW-1:0] w_sel, r_sel;
  logic          grant_w, grant_r;
  logic [PW-1:0] head_tag;

  assign present   = stage_full_reg & init_done_reg;
  assign consume   = present & i_mem_ready;
  assign can_load  = ~stage_full_reg | consume;
  assign have_tag  = (tag_count_reg != '0);
  assign last_beat = (beat_cnt_reg == 4'(READ_BURST - 1));
  assign pop       = i_mem_rdata_valid & have_tag & last_beat;
  // A burst completing this cycle frees its slot in time for a new push
  assign tag_space = (tag_count_reg != CW'(TAG_DEPTH)) | pop;
  assign head_tag  = tag_mem[tag_rd_reg];

  assign {w_found, w_sel} = rr_pick(i_wdata_have, wptr_reg);
  assign {r_found, r_sel} = rr_pick(i_rdata_req, rptr_reg);

  // Pick at most one grant, class order decided by the current mode
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (can_load && !i_reset) begin
      if (mode_reg == WRITE_PRI) begin
        if (w_found)                    grant_w = 1'b1;
        else if (r_found && tag_space)  grant_r = 1'b1;
      end else begin
        if (r_found && tag_space)       grant_r = 1'b1;
        else if (w_found)               grant_w = 1'b1;
      end
    end
  end

  // Write streak limits write starvation of pending reads
  always_comb begin
    streak_next = streak_reg;
    mode_next   = mode_reg;
    if (grant_r)
      streak_next = '0;
    else if (grant_w && (|i_rdata_req) && (streak_reg != SW'(WRITE_STREAK)))
      streak_next = streak_reg + SW'(1);
    if (grant_r)
      mode_next = WRITE_PRI;
    else if (streak_next == SW'(WRITE_STREAK))
      mode_next = READ_PRI;
  end

  assign o_wdata_accept       = grant_w ? onehot(w_sel) : '0;
  assign o_rdata_req_accepted = grant_r ? onehot(r_sel) : '0;

  // Command stage occupancy and registered calibration flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      init_done_reg   <= 1'b0;
      stage_full_reg  <= 1'b0;
      stage_write_reg <= 1'b0;
    end else begin
      init_done_reg  <= i_mem_init_done;
      stage_full_reg <= (stage_full_reg & ~consume) | grant_w | grant_r;
      if (grant_w)      stage_write_reg <= 1'b1;
      else if (grant_r) stage_write_reg <= 1'b0;
    end
  end

  // Command stage payload, loaded from the granted port
  always_ff @(posedge i_clk) begin
    if (grant_w) begin
      stage_addr_reg <= waddr_arr[w_sel];
      stage_data_reg <= wdata_arr[w_sel];
    end else if (grant_r) begin
      stage_addr_reg <= raddr_arr[r_sel];
    end
  end

  // Mode FSM with streak counter and round-robin pointers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_reg   <= WRITE_PRI;
      streak_reg <= '0;
      wptr_reg   <= '0;
      rptr_reg   <= '0;
    end else begin
      mode_reg   <= mode_next;
      streak_reg <= streak_next;
      if (grant_w) wptr_reg <= w_sel;
      if (grant_r) rptr_reg <= r_sel;
    end
  end

  // Tag storage: port index of each outstanding read burst
  always_ff @(posedge i_clk) begin
    if (grant_r) tag_mem[tag_wr_reg] <= r_sel;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tag_wr_reg    <= '0;
      tag_rd_reg    <= '0;
      tag_count_reg <= '0;
    end else begin
      if (grant_r)
        tag_wr_reg <= (tag_wr_reg == TAW'(TAG_DEPTH - 1)) ? '0 : tag_wr_reg + TAW'(1);
      if (pop)
        tag_rd_reg <= (tag_rd_reg == TAW'(TAG_DEPTH - 1)) ? '0 : tag_rd_reg + TAW'(1);
      if (grant_r && !pop)      tag_count_reg <= tag_count_reg + CW'(1);
      else if (!grant_r && pop) tag_count_reg <= tag_count_reg - CW'(1);
    end
  end

  // Return path: register beat, steer to head tag, count beats within burst
  always_ff @(posedge i_clk) begin
    rdata_reg <= i_mem_rdata;
    if (i_reset) begin
      rvalid_reg   <= '0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      rvalid_reg <= '0;
      last_reg   <= 1'b0;
      if (i_mem_rdata_valid) begin
        if (have_tag) begin
          rvalid_reg   <= onehot(head_tag);
          last_reg     <= last_beat;
          beat_cnt_reg <= last_beat ? 4'd0 : beat_cnt_reg + 4'd1;
        end else begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign o_rdata          = rdata_reg;
  assign o_rdata_valid    = rvalid_reg;
  assign o_rdata_lastword = last_reg;
  assign o_err_unexpected = err_reg;
  assign o_outstanding    = tag_count_reg;

  assign o_mem_address    = stage_addr_reg;
  assign o_mem_wdata      = stage_data_reg;
  assign o_mem_size       = stage_write_reg ? 4'd1 : 4'(READ_BURST);
  assign o_mem_write_req  = present & stage_write_reg;
  assign o_mem_read_req   = present & ~stage_write_reg;
  assign o_mem_burstbegin = present;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed scenarios with literal expectations
// plus a queue-based reference model compared on every falling edge.
module tb_mem_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 25;
  localparam int DW = 128;
  localparam int RB = 8;
  localparam int TD = 8;
  localparam int WS = 4;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [N*AW-1:0] i_waddr, i_raddr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    i_wdata_have, i_rdata_req;
  logic [N-1:0]    o_wdata_accept, o_rdata_req_accepted, o_rdata_valid;
  logic [DW-1:0]   o_rdata, o_mem_wdata, i_mem_rdata;
  logic            o_rdata_lastword;
  logic [AW-1:0]   o_mem_address;
  logic [3:0]      o_mem_size;
  logic            o_mem_write_req, o_mem_read_req, o_mem_burstbegin, o_err_unexpected;
  logic [3:0]      o_outstanding;
  logic            i_mem_ready, i_mem_rdata_valid, i_mem_init_done;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(
    .NUM_PORTS(N), .ADDR_BITS(AW), .DATA_WIDTH(DW),
    .READ_BURST(RB), .TAG_DEPTH(TD), .WRITE_STREAK(WS)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wdata_have(i_wdata_have),
    .o_wdata_accept(o_wdata_accept),
    .i_raddr(i_raddr), .i_rdata_req(i_rdata_req),
    .o_rdata_req_accepted(o_rdata_req_accepted),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_rdata_lastword(o_rdata_lastword),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
    .o_mem_write_req(o_mem_write_req), .o_mem_read_req(o_mem_read_req),
    .o_mem_burstbegin(o_mem_burstbegin), .o_err_unexpected(o_err_unexpected),
    .o_outstanding(o_outstanding),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_init_done(i_mem_init_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_on = 0;
  bit            m_init, m_full, m_wr, m_last, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata;
  logic [N-1:0]  m_rvalid;
  int            m_mode, m_streak, m_wptr, m_rptr, m_beat;
  int            m_tags[$];

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++) begin
      automatic int c = (ptr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Compare DUT against the model, then advance the model one clock
  always @(negedge i_clk) begin
    bit present, consume, can, pop, space, gw, gr;
    int wi, ri;
    logic [N-1:0] ew, er;
    present = m_full && m_init;
    consume = present && i_mem_ready;
    can     = !m_full || consume;
    pop     = i_mem_rdata_valid && (m_tags.size() > 0) && (m_beat == RB - 1);
    space   = (m_tags.size() < TD) || pop;
    wi = pick(i_wdata_have, m_wptr);
    ri = pick(i_rdata_req, m_rptr);
    gw = 0; gr = 0;
    if (can && !i_reset) begin
      if (m_mode == 0) begin
        if (wi >= 0) gw = 1; else if (ri >= 0 && space) gr = 1;
      end else begin
        if (ri >= 0 && space) gr = 1; else if (wi >= 0) gw = 1;
      end
    end
    ew = gw ? (N'(1) << wi) : '0;
    er = gr ? (N'(1) << ri) : '0;
    if (m_on) begin
      if (!i_reset) begin
        check("m_wacc", o_wdata_accept, ew);
        check("m_racc", o_rdata_req_accepted, er);
      end
      check("m_wreq", o_mem_write_req, present && m_wr);
      check("m_rreq", o_mem_read_req, present && !m_wr);
      check("m_bb", o_mem_burstbegin, present);
      if (present) begin
        check("m_addr", o_mem_address, m_addr);
        check("m_size", o_mem_size, m_wr ? 1 : RB);
        if (m_wr) check("m_wdata", o_mem_wdata, m_data);
      end
      check("m_rvalid", o_rdata_valid, m_rvalid);
      check("m_last", o_rdata_lastword, m_last);
      check("m_err", o_err_unexpected, m_err);
      check("m_outst", o_outstanding, m_tags.size());
      if (m_rvalid != '0) check("m_rdata", o_rdata, m_rdata);
    end
    if (i_reset) begin
      m_on = 1; m_init = 0; m_full = 0; m_wr = 0; m_last = 0; m_err = 0;
      m_rvalid = '0; m_mode = 0; m_streak = 0; m_wptr = 0; m_rptr = 0; m_beat = 0;
      m_tags.delete();
    end else begin
      m_rvalid = '0; m_last = 0;
      if (i_mem_rdata_valid) begin
        if (m_tags.size() > 0) begin
          m_rvalid = N'(1) << m_tags[0];
          if (m_beat == RB - 1) begin
            m_last = 1; m_beat = 0; void'(m_tags.pop_front());
          end else m_beat++;
        end else m_err = 1;
      end
      m_rdata = i_mem_rdata;
      if (gr) m_tags.push_back(ri);
      if (consume) m_full = 0;
      if (gw) begin
        m_full = 1; m_wr = 1;
        m_addr = i_waddr[wi*AW +: AW]; m_data = i_wdata[wi*DW +: DW];
        m_wptr = wi;
      end
      if (gr) begin
        m_full = 1; m_wr = 0; m_addr = i_raddr[ri*AW +: AW]; m_rptr = ri;
      end
      if (gr) m_streak = 0;
      else if (gw && (|i_rdata_req) && m_streak < WS) m_streak++;
      if (gr) m_mode = 0;
      else if (m_streak >= WS) m_mode = 1;
      m_init = i_mem_init_done;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beats(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata = DW'(base + k);
      tick();
    end
    i_mem_rdata_valid = 1'b0;
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_waddr = '0; i_raddr = '0; i_wdata = '0;
    i_wdata_have = '0; i_rdata_req = '0; i_mem_ready = 1'b0;
    i_mem_rdata = '0; i_mem_rdata_valid = 1'b0; i_mem_init_done = 1'b0;
    repeat (3) tick();
    i_reset = 1'b0; i_mem_init_done = 1'b1;
    #1;
    check("rst_wreq", o_mem_write_req, 0);
    check("rst_rreq", o_mem_read_req, 0);
    check("rst_rvalid", o_rdata_valid, 0);
    check("rst_outst", o_outstanding, 0);
    check("rst_err", o_err_unexpected, 0);
    tick();

    // Single write, stage held while controller not ready
    i_waddr[0 +: AW] = 25'h100;
    i_wdata[0 +: DW] = {16{8'hA5}};
    i_wdata_have = 2'b01;
    #1 check("t1_accept", o_wdata_accept, 2'b01);
    tick();
    i_wdata_have = '0;
    #1;
    check("t1_wreq", o_mem_write_req, 1);
    check("t1_size", o_mem_size, 1);
    check("t1_addr", o_mem_address, 25'h100);
    check("t1_wdata", o_mem_wdata, {16{8'hA5}});
    repeat (2) begin
      tick();
      #1;
      check("t1_hold_wreq", o_mem_write_req, 1);
      check("t1_hold_addr", o_mem_address, 25'h100);
    end
    i_mem_ready = 1'b1;
    tick();
    #1 check("t1_consumed", o_mem_write_req, 0);

    // Two ports reading, round-robin 0,1,0,1
    i_raddr[0 +: AW] = 25'h200;
    i_raddr[AW +: AW] = 25'h300;
    i_rdata_req = 2'b01;
    #1 check("t2_g0", o_rdata_req_accepted, 2'b01);
    tick();
    i_rdata_req = 2'b11;
    #1 check("t2_g1", o_rdata_req_accepted, 2'b10);
    tick();
    #1 check("t2_g2", o_rdata_req_accepted, 2'b01);
    tick();
    i_rdata_req = 2'b10;
    #1 check("t2_g3", o_rdata_req_accepted, 2'b10);
    tick();
    i_rdata_req = '0;
    #1 check("t2_outst", o_outstanding, 4);
    for (int k = 1; k <= 16; k++) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata = DW'(k);
      tick();
      i_mem_rdata_valid = 1'b0;
      #1;
      check("t2_rvalid", o_rdata_valid, (k <= 8) ? 2'b01 : 2'b10);
      check("t2_last", o_rdata_lastword, (k == 8 || k == 16));
      check("t2_rdata", o_rdata, k);
    end
    beats(16, 100);
    tick();
    #1 check("t2_drained", o_outstanding, 0);

    // Write streak: port 1 writes, port 0 reads -> 4 writes then 1 read
    i_waddr[AW +: AW] = 25'h400;
    i_wdata[DW +: DW] = {16{8'h3C}};
    i_raddr[0 +: AW] = 25'h500;
    i_wdata_have = 2'b10;
    i_rdata_req = 2'b01;
    for (int c = 0; c < 15; c++) begin
      #1;
      check("t3_wacc", o_wdata_accept, (c % 5 == 4) ? 2'b00 : 2'b10);
      check("t3_racc", o_rdata_req_accepted, (c % 5 == 4) ? 2'b01 : 2'b00);
      tick();
    end
    i_wdata_have = '0;
    i_rdata_req = '0;
    tick();
    beats(3 * RB, 200);
    tick();
    #1 check("t3_drained", o_outstanding, 0);

    // Tag FIFO full: 8 accepted, 9th held until the last beat of burst 1
    n = 0;
    i_rdata_req = 2'b01;
    repeat (12) begin
      #1;
      if (o_rdata_req_accepted[0]) n++;
      tick();
    end
    check("t4_grants", n, 8);
    check("t4_outst_full", o_outstanding, 8);
    for (int k = 1; k <= RB; k++) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata = DW'(300 + k);
      #1 check("t4_held_or_acc", o_rdata_req_accepted, (k == RB) ? 2'b01 : 2'b00);
      tick();
    end
    i_mem_rdata_valid = 1'b0;
    i_rdata_req = '0;
    #1 check("t4_outst_keep", o_outstanding, 8);
    beats(8 * RB, 400);
    tick();
    #1 check("t4_drained", o_outstanding, 0);

    // Unexpected read data with no outstanding tag
    i_mem_rdata_valid = 1'b1;
    tick();
    i_mem_rdata_valid = 1'b0;
    #1;
    check("t5_err", o_err_unexpected, 1);
    check("t5_rvalid", o_rdata_valid, 0);
    repeat (3) tick();
    #1 check("t5_sticky", o_err_unexpected, 1);

    // Reset in the middle of a burst
    i_raddr[AW +: AW] = 25'h600;
    i_rdata_req = 2'b10;
    #1 check("t6_acc", o_rdata_req_accepted, 2'b10);
    tick();
    i_rdata_req = '0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata = DW'(500 + k);
      if (k == 3) i_reset = 1'b1;
      tick();
    end
    i_mem_rdata_valid = 1'b0;
    i_reset = 1'b0;
    #1;
    check("t6_rvalid", o_rdata_valid, 0);
    check("t6_last", o_rdata_lastword, 0);
    check("t6_err", o_err_unexpected, 0);
    check("t6_outst", o_outstanding, 0);
    check("t6_req", {o_mem_write_req, o_mem_read_req, o_mem_burstbegin}, 3'b000);
    tick();
    i_rdata_req = 2'b10;
    #1 check("t6_acc2", o_rdata_req_accepted, 2'b10);
    tick();
    i_rdata_req = '0;
    tick();
    for (int k = 1; k <= RB; k++) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata = DW'(600 + k);
      tick();
      i_mem_rdata_valid = 1'b0;
      #1;
      check("t6_rvalid2", o_rdata_valid, 2'b10);
      check("t6_last2", o_rdata_lastword, k == RB);
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Single-clock, N-port successor to the DDR request front end.
- Arbitrates NUM_PORTS write ports and NUM_PORTS read-request ports onto one memory command interface through a one-entry registered command stage.
- Tracks outstanding read bursts in a tag FIFO and routes returning read beats back to the requesting port, flagging the last beat of each burst.
- Sits between cache/port logic and the memory controller when both run on the same clock.

Parameters:
- NUM_PORTS, 2: number of requester ports, 1..8.
- ADDR_BITS, 25: memory word address width.
- DATA_WIDTH, 128: data beat width.
- READ_BURST, 8: beats per read burst, 1..15. Writes are always single-beat.
- TAG_DEPTH, 8: maximum outstanding read bursts, power of 2.
- WRITE_STREAK, 4: maximum consecutive write grants while reads are pending.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_waddr  in  NUM_PORTS*ADDR_BITS  per-port write address; port p occupies slice p.
- i_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- i_wdata_have  in  NUM_PORTS  write request valid.
- o_wdata_accept  out  NUM_PORTS  write granted this cycle; at most one bit set.
- i_raddr  in  NUM_PORTS*ADDR_BITS  per-port read burst address.
- i_rdata_req  in  NUM_PORTS  read request valid.
- o_rdata_req_accepted  out  NUM_PORTS  read granted this cycle; at most one bit set.
- o_rdata  out  DATA_WIDTH  returned beat, shared by all ports.
- o_rdata_valid  out  NUM_PORTS  one-hot: o_rdata belongs to this port.
- o_rdata_lastword  out  1  final beat of the current burst.
- o_mem_address  out  ADDR_BITS  command address.
- o_mem_wdata  out  DATA_WIDTH  command write data.
- o_mem_size  out  4  burst size: 1 for writes, READ_BURST for reads.
- o_mem_write_req  out  1  write command valid.
- o_mem_read_req  out  1  read command valid.
- o_mem_burstbegin  out  1  asserted together with either request.
- o_err_unexpected  out  1  sticky: read data arrived with no outstanding tag.
- o_outstanding  out  $clog2(TAG_DEPTH)+1  number of tag FIFO entries.
- i_mem_ready  in  1  controller accepts the command this cycle.
- i_mem_rdata  in  DATA_WIDTH  read beat.
- i_mem_rdata_valid  in  1  read beat valid.
- i_mem_init_done  in  1  controller calibrated.

Behaviour:
- Reset (synchronous): command stage empty, tag FIFO empty, beat counter 0, streak counter 0, round-robin pointers 0, mode WRITE_PRI, o_err_unexpected 0. All request, valid, accept and lastword outputs are 0.
- Command stage:
  - Holds one command.
  - Presented to the controller, with req/burstbegin high, only when full and the registered i_mem_init_done is 1.
  - Consumed when presented and i_mem_ready=1.
  - May load in the same cycle it is consumed (zero-bubble). A load occurs only when the stage is empty or being consumed.
- Grant:
  - Combinational, at most one grant per cycle, issued only when the stage can load.
  - Read grant additionally requires tag FIFO not full.
  - Granted port's data is loaded into the stage on the next edge.
  - A request must stay high until accepted.
- Mode FSM, WRITE_PRI / READ_PRI:
  - WRITE_PRI: grant a write if any is pending, else a read.
  - READ_PRI: grant a read if any is pending and the tag FIFO has space, else a write.
  - Streak counter increments on each write grant while any read request is pending. It clears on any read grant.
  - When the streak reaches WRITE_STREAK, next mode is READ_PRI.
  - After a read grant in READ_PRI, next mode is WRITE_PRI.
- Round-robin within each class, with separate read and write pointers:
  - Search starts at pointer+1 modulo NUM_PORTS.
  - Pointer updates to the granted port.
- Tag FIFO:
  - Push of the port index on read grant.
  - Pop on the last beat of a burst.
  - Push and pop in the same cycle keeps the count; this is legal when full, and the read grant is then permitted.
- Return path, 1-cycle latency:
  - o_rdata is registered i_mem_rdata.
  - o_rdata_valid is one-hot of the head tag, asserted the cycle after i_mem_rdata_valid.
  - Beat counter counts 0..READ_BURST-1. On beat READ_BURST-1: o_rdata_lastword=1, counter wraps to 0, tag pops.
  - READ_BURST=1 means every beat is last.
- Beat arriving with tag FIFO empty: o_rdata_valid stays 0, o_err_unexpected sets, counter unchanged.
- Reset mid-burst discards all outstanding tags and the stage contents.

Test Plan:
- Port 0 write, addr 0x100, data 0xA5.. -> o_wdata_accept[0] same cycle. Next cycle o_mem_write_req=1, size=1, addr 0x100. With i_mem_ready held 0, the command holds stable.
- Ports 0 and 1 read continuously, READ_BURST=8 -> grants alternate 0,1,0,1. Returned 16 beats show o_rdata_valid 01 x8 then 10 x8, lastword on beats 8 and 16.
- Port 1 writes continuously while port 0 reads, WRITE_STREAK=4 -> exactly 4 write grants, then 1 read grant, repeating.
- TAG_DEPTH=8 with no read data returned -> 8 reads accepted, 9th held, o_outstanding=8. On the last beat of burst 1, the 9th read is accepted in the same cycle and o_outstanding stays 8.
- i_mem_rdata_valid with no outstanding reads -> o_err_unexpected=1 and stays set; no o_rdata_valid.
- i_reset asserted at beat 3 of a burst -> next cycle all outputs 0 and o_outstanding=0. A subsequent burst returns with lastword on its 8th beat.
